// File: rtl/mem_burst_ctrl_if.sv
// Bundle of command, write-stream, read-stream and memory-side signals for
// mem_burst_ctrl. The master modport is the controller, which initiates memory accesses.
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  // Handshakes: cmd and wr transfer a beat on a rising edge where valid & ready
  // are both high. rd has no ready: every cycle with rd_valid high is one beat.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_data_out;
  logic [1:0]        dbg_state;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, mem_data_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy,
           mem_address, mem_data_in, mem_write_en, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, mem_data_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy,
           mem_address, mem_data_in, mem_write_en, dbg_state
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller for a single-port synchronous memory: splits write/read burst
// commands into one memory access per beat, with a 2-stage read return pipeline.
module mem_burst_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input logic             clk,
  input logic             rst_n,
  mem_burst_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              mem_write_en_q;
  logic              p1_valid, p1_last;
  logic              p2_valid, p2_last;
  logic              rd_valid_q, rd_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              cmd_ready_w;

  // Masking with done keeps a write burst's completion cycle closed to new commands.
  assign cmd_ready_w      = (state == IDLE) && !done_q;
  assign bus.cmd_ready    = cmd_ready_w;
  assign bus.wr_ready     = (state == WRITE);
  assign bus.busy         = (state != IDLE);
  assign bus.dbg_state    = state;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_data_in  = mem_data_in_q;
  assign bus.mem_write_en = mem_write_en_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_last      = rd_last_q;
  assign bus.done         = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      mem_address_q  <= '0;
      mem_data_in_q  <= '0;
      mem_write_en_q <= 1'b0;
      p1_valid       <= 1'b0;
      p1_last        <= 1'b0;
      p2_valid       <= 1'b0;
      p2_last        <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_data_q      <= '0;
      done_q         <= 1'b0;
    end else begin
      mem_write_en_q <= 1'b0;
      p1_valid       <= 1'b0;
      p1_last        <= 1'b0;
      // p1: address on the memory port; p2: memory data_out valid; then captured.
      p2_valid       <= p1_valid;
      p2_last        <= p1_last;
      rd_valid_q     <= p2_valid;
      rd_last_q      <= p2_valid && p2_last;
      done_q         <= p2_valid && p2_last;
      if (p2_valid) rd_data_q <= bus.mem_data_out;

      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_w) begin
            addr      <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            state     <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            mem_address_q  <= addr;
            mem_data_in_q  <= bus.wr_data;
            mem_write_en_q <= 1'b1;
            addr           <= addr + 1'b1;
            remaining      <= remaining - 1'b1;
            if (remaining == '0) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        READ: begin
          mem_address_q <= addr;
          addr          <= addr + 1'b1;
          remaining     <= remaining - 1'b1;
          p1_valid      <= 1'b1;
          p1_last       <= (remaining == '0);
          if (remaining == '0) state <= DRAIN;
        end
        DRAIN: begin
          // Leave after the done cycle so busy covers every returned beat.
          if (rd_last_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
